// File: rtl/cwb_pkg.sv
//------------------------------------------------------------------------------
// Module : cwb_pkg
// Brief  : Shared widths and pointer helpers for circular_window_buffer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cwb_pkg;

    localparam int unsigned CWB_SIZE = 16;

    function automatic int unsigned ptr_w(input int unsigned size);
        return $clog2(size);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    typedef logic [$clog2(CWB_SIZE)-1:0]   ptr_t;
    typedef logic [$clog2(CWB_SIZE+1)-1:0] cnt_t;

    // Size is a power of two, so masking equals a truncated pointer add.
    function automatic int unsigned wrap_add(input int unsigned ptr,
                                             input int unsigned n,
                                             input int unsigned size);
        return (ptr + n) & (size - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cwb_slot.sv
//------------------------------------------------------------------------------
// Module : cwb_slot
// Brief  : One storage entry; captures its element of a multi-element push.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cwb_slot
    import cwb_pkg::*;
#(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned WRITE_SIZE = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SLOT       = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(SIZE)-1:0]               wr_ptr_i,
    input  logic [WRITE_SIZE-1:0][DATA_WIDTH-1:0] in_i,
    input  logic [$clog2(WRITE_SIZE+1)-1:0]       write_count_i,
    input  logic                                  push_i,
    output logic [DATA_WIDTH-1:0]                 data_o
);

    localparam int unsigned SEL = ptr_w(SIZE);
    localparam int unsigned WCW = $clog2(WRITE_SIZE + 1);

    logic [SEL-1:0]        w_offset;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        data_d   = data_q;
        w_offset = SEL'(SLOT) - wr_ptr_i;
        for (int k = 0; k < int'(WRITE_SIZE); k++) begin
            if (push_i && (w_offset == SEL'(k)) && (WCW'(k) < write_count_i)) begin
                data_d = in_i[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/circular_window_buffer.sv
//------------------------------------------------------------------------------
// Module : circular_window_buffer
// Brief  : Circular buffer with multi-element push and a READ_SIZE read window.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module circular_window_buffer
    import cwb_pkg::*;
#(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned WRITE_SIZE = 4,
    parameter int unsigned READ_SIZE  = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WRITE_SIZE-1:0][DATA_WIDTH-1:0] in,
    input  logic [$clog2(WRITE_SIZE+1)-1:0]       write_count,
    input  logic                                  write_valid,
    output logic                                  write_ready,
    input  logic [$clog2(READ_SIZE+1)-1:0]        read_count,
    input  logic                                  read_en,
    output logic [READ_SIZE-1:0][DATA_WIDTH-1:0]  out,
    output logic [$clog2(READ_SIZE+1)-1:0]        out_valid,
    output logic [$clog2(SIZE+1)-1:0]             count,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  err
);

    localparam int unsigned SEL = ptr_w(SIZE);
    localparam int unsigned CW  = cnt_w(SIZE);
    localparam int unsigned RCW = $clog2(READ_SIZE + 1);

    logic [SEL-1:0] wr_ptr_q, wr_ptr_d;
    logic [SEL-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;
    logic [CW-1:0]  w_free;
    logic           w_push_fire, w_pop_fire;
    logic [SIZE-1:0][DATA_WIDTH-1:0] w_mem;

    // Both legality checks see only the pre-edge occupancy.
    assign w_free      = CW'(SIZE) - count_q;
    assign write_ready = w_free >= CW'(write_count);
    assign w_push_fire = write_valid && write_ready && (write_count != '0);
    assign w_pop_fire  = read_en && (CW'(read_count) <= count_q) && (read_count != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q
                 + (w_push_fire ? CW'(write_count) : '0)
                 - (w_pop_fire  ? CW'(read_count)  : '0);
        err_d    = (write_valid && !write_ready)
                 || (read_en && (CW'(read_count) > count_q));
        if (w_push_fire) begin
            wr_ptr_d = SEL'(wrap_add(32'(wr_ptr_q), 32'(write_count), SIZE));
        end
        if (w_pop_fire) begin
            rd_ptr_d = SEL'(wrap_add(32'(rd_ptr_q), 32'(read_count), SIZE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    for (genvar s = 0; s < int'(SIZE); s++) begin : g_slot
        cwb_slot #(
            .SIZE       (SIZE),
            .WRITE_SIZE (WRITE_SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .SLOT       (s)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .wr_ptr_i      (wr_ptr_q),
            .in_i          (in),
            .write_count_i (write_count),
            .push_i        (w_push_fire),
            .data_o        (w_mem[s])
        );
    end

    for (genvar j = 0; j < int'(READ_SIZE); j++) begin : g_rd_mux
        assign out[j] = w_mem[SEL'(wrap_add(32'(rd_ptr_q), j, SIZE))];
    end

    assign out_valid = (count_q >= CW'(READ_SIZE)) ? RCW'(READ_SIZE) : RCW'(count_q);
    assign count     = count_q;
    assign full      = count_q == CW'(SIZE);
    assign empty     = count_q == '0;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_circular_window_buffer.sv
//------------------------------------------------------------------------------
// Module : tb_circular_window_buffer
// Brief  : Directed vector bench for circular_window_buffer (16/4/4/8).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_circular_window_buffer;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0][7:0]      in = '0;
    logic [2:0]           write_count = '0;
    logic                 write_valid = 1'b0;
    logic                 write_ready;
    logic [2:0]           read_count = '0;
    logic                 read_en = 1'b0;
    logic [3:0][7:0]      out;
    logic [2:0]           out_valid;
    logic [4:0]           count;
    logic                 full;
    logic                 empty;
    logic                 err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    circular_window_buffer #(
        .SIZE(16), .WRITE_SIZE(4), .READ_SIZE(4), .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .write_count (write_count),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .read_count  (read_count),
        .read_en     (read_en),
        .out         (out),
        .out_valid   (out_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    typedef struct {
        logic       rst;
        logic       wv;
        logic [2:0] wc;
        logic [7:0] d [4];
        logic       re;
        logic [2:0] rc;
        logic       wrdy;
        int         cnt;
        int         ov;
        logic       e_err;
        logic [3:0] omask;
        logic [7:0] eo [4];
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    endtask

    task automatic add(input logic r, input logic wv, input int wc,
                       input int d0, input int d1, input int d2, input int d3,
                       input logic re, input int rc, input logic wrdy,
                       input int cnt, input int ov, input logic e_err, input logic [3:0] omask,
                       input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.rst = r; v.wv = wv; v.wc = 3'(wc);
        v.d[0] = 8'(d0); v.d[1] = 8'(d1); v.d[2] = 8'(d2); v.d[3] = 8'(d3);
        v.re = re; v.rc = 3'(rc); v.wrdy = wrdy;
        v.cnt = cnt; v.ov = ov; v.e_err = e_err; v.omask = omask;
        v.eo[0] = 8'(o0); v.eo[1] = 8'(o1); v.eo[2] = 8'(o2); v.eo[3] = 8'(o3);
        vq.push_back(v);
    endtask

    task automatic check_state(input int idx, input int cnt, input int ov, input logic e_err,
                               input logic [3:0] omask, input logic [7:0] eo [4]);
        chk("count", idx, int'(count), cnt);
        chk("out_valid", idx, int'(out_valid), ov);
        chk("err", idx, int'(err), int'(e_err));
        chk("full", idx, int'(full), int'(cnt == 16));
        chk("empty", idx, int'(empty), int'(cnt == 0));
        for (int j = 0; j < 4; j++) begin
            if (omask[j]) chk($sformatf("out%0d", j), idx, int'(out[j]), int'(eo[j]));
        end
    endtask

    initial begin
        logic [7:0] zeros [4];
        zeros = '{8'd0, 8'd0, 8'd0, 8'd0};

        //  rst wv wc  d0..d3            re rc wrdy cnt ov err mask    o0..o3
        add(0, 1, 3,   1,  2,  3,  0,    0, 0, 1,   3, 3, 0, 4'b0111, 1, 2, 3, 0);
        add(0, 0, 0,   0,  0,  0,  0,    1, 3, 1,   0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 4,  10, 11, 12, 13,    0, 0, 1,   4, 4, 0, 4'b1111, 10, 11, 12, 13);
        add(0, 1, 4,  14, 15, 16, 17,    0, 0, 1,   8, 4, 0, 4'b1111, 10, 11, 12, 13);
        add(0, 1, 4,  18, 19, 20, 21,    0, 0, 1,  12, 4, 0, 4'b1111, 10, 11, 12, 13);
        add(0, 1, 4,  22, 23, 24, 25,    0, 0, 1,  16, 4, 0, 4'b1111, 10, 11, 12, 13);
        add(0, 1, 4,  90, 91, 92, 93,    0, 0, 0,  16, 4, 1, 4'b1111, 10, 11, 12, 13);
        add(0, 0, 1,   0,  0,  0,  0,    0, 0, 0,  16, 4, 0, 4'b1111, 10, 11, 12, 13);
        add(0, 0, 0,   0,  0,  0,  0,    1, 1, 1,  15, 4, 0, 4'b1111, 11, 12, 13, 14);
        add(0, 1, 2,  30, 31,  0,  0,    1, 2, 0,  13, 4, 1, 4'b1111, 13, 14, 15, 16);
        add(0, 0, 0,   0,  0,  0,  0,    1, 1, 1,  12, 4, 0, 4'b1111, 14, 15, 16, 17);
        add(0, 1, 4,  40, 41, 42, 43,    1, 2, 1,  14, 4, 0, 4'b1111, 16, 17, 18, 19);
        add(0, 0, 0,   0,  0,  0,  0,    1, 4, 1,  10, 4, 0, 4'b1111, 20, 21, 22, 23);
        add(0, 0, 0,   0,  0,  0,  0,    1, 4, 1,   6, 4, 0, 4'b1111, 24, 25, 40, 41);
        add(0, 0, 0,   0,  0,  0,  0,    1, 4, 1,   2, 2, 0, 4'b0011, 42, 43, 0, 0);
        add(0, 0, 0,   0,  0,  0,  0,    1, 3, 1,   2, 2, 1, 4'b0011, 42, 43, 0, 0);
        add(0, 0, 0,   0,  0,  0,  0,    1, 2, 1,   0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 4,  50, 51, 52, 53,    0, 0, 1,   4, 4, 0, 4'b1111, 50, 51, 52, 53);
        add(0, 0, 0,   0,  0,  0,  0,    1, 4, 1,   0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 3,  60, 61, 62, 99,    0, 0, 1,   3, 3, 0, 4'b0111, 60, 61, 62, 0);
        add(0, 0, 0,   0,  0,  0,  0,    1, 3, 1,   0, 0, 0, 4'b0000, 0, 0, 0, 0);
        // Pointers now sit at 14: this push straddles the wrap.
        add(0, 1, 4, 'hA0, 'hA1, 'hA2, 'hA3, 0, 0, 1, 4, 4, 0, 4'b1111, 'hA0, 'hA1, 'hA2, 'hA3);
        add(0, 1, 1, 'hB0,  0,  0,  0,   1, 4, 1,   1, 1, 0, 4'b0001, 'hB0, 0, 0, 0);
        add(0, 1, 0,   7,  7,  7,  7,    1, 0, 1,   1, 1, 0, 4'b0001, 'hB0, 0, 0, 0);
        add(1, 1, 4,   1,  2,  3,  4,    1, 1, 1,   0, 0, 0, 4'b1111, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state(-1, 0, 0, 1'b0, 4'b1111, zeros);
        chk("write_ready", -1, int'(write_ready), 1);

        foreach (vq[i]) begin
            @(negedge clk);
            rst         = vq[i].rst;
            write_valid = vq[i].wv;
            write_count = vq[i].wc;
            for (int k = 0; k < 4; k++) in[k] = vq[i].d[k];
            read_en     = vq[i].re;
            read_count  = vq[i].rc;
            #1;
            if (!vq[i].rst) chk("write_ready", i, int'(write_ready), int'(vq[i].wrdy));
            @(posedge clk);
            #1;
            check_state(i, vq[i].cnt, vq[i].ov, vq[i].e_err, vq[i].omask, vq[i].eo);
        end

        // err must be a single-cycle pulse after a rejected pop.
        @(negedge clk);
        rst = 1'b0; write_valid = 1'b0; write_count = '0;
        read_en = 1'b1; read_count = 3'd1;
        @(posedge clk); #1;
        chk("err_pulse_hi", 100, int'(err), 1);
        @(negedge clk);
        read_en = 1'b0; read_count = '0;
        @(posedge clk); #1;
        chk("err_pulse_lo", 101, int'(err), 0);
        chk("count_hold", 101, int'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
